// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes one operand bit
// per clock, LSB first. Produces sum, carry-out and signed overflow, with a
// one-cycle done pulse.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_c;
  logic             c_c;
  logic [WIDTH-1:0] res_shift_c;
  logic             load_c;

  // Single full-adder cell on the current LSBs; new bit enters the result MSB
  always_comb begin
    s_c         = a_q[0] ^ b_q[0] ^ carry_q;
    c_c         = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    res_shift_c = WIDTH'({s_c, res_q} >> 1);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    load_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load_c = 1'b1;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_c;
        res_d   = res_shift_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB
          state_d = DONE;
          sum_d   = res_shift_c;
          cout_d  = c_c;
          ovf_d   = carry_q ^ c_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        if (start) begin
          load_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand latch; subtract becomes a + ~b + ~cin
    if (load_c) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = op ? ~b : b;
      carry_d = op ? ~cin : cin;
      res_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: WIDTH=8, 2 and 1 instances share stimulus and
// are checked every cycle against an arithmetic model, plus literal checks.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int vectors;
  int miscompares;

  bit_serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .a(a), .b(b), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  bit_serial_adder #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .a(a[1:0]), .b(b[1:0]), .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2)
  );

  bit_serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .a(a[0:0]), .b(b[0:0]), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  // Width-w result from plain arithmetic: {ovf, cout, sum}
  function automatic logic [33:0] ref_op(input int w, input logic [7:0] av,
                                         input logic [7:0] bv, input logic o,
                                         input logic c);
    logic [32:0] mask;
    logic [32:0] bb;
    logic [32:0] t;
    logic        ci;
    logic        ov;
    mask = (33'd1 << w) - 33'd1;
    bb   = (o ? ~{25'b0, bv} : {25'b0, bv}) & mask;
    ci   = o ? ~c : c;
    t    = ({25'b0, av} & mask) + bb + {32'b0, ci};
    ov   = (av[w-1] == bb[w-1]) && (t[w-1] != av[w-1]);
    return {ov, t[w], t[31:0]};
  endfunction

  function automatic int wid_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 2 : 1);
  endfunction

  // Model: an accepted request completes wid cycles later with the arithmetic result
  int          m_left [3];
  logic        m_busy [3];
  logic        m_done [3];
  logic        m_cout [3];
  logic        m_ovf  [3];
  logic [7:0]  m_sum  [3];
  logic [33:0] m_pend [3];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_left[k] <= 0;
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_cout[k] <= 1'b0;
        m_ovf[k]  <= 1'b0;
        m_sum[k]  <= 8'h00;
        m_pend[k] <= '0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_left[k] > 0) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_sum[k]  <= m_pend[k][7:0];
            m_cout[k] <= m_pend[k][32];
            m_ovf[k]  <= m_pend[k][33];
            m_done[k] <= 1'b1;
            m_busy[k] <= 1'b0;
          end
        end else if (start) begin
          m_pend[k] <= ref_op(wid_of(k), a, b, op, cin);
          m_left[k] <= wid_of(k);
          m_busy[k] <= 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of all three instances against the model
  always @(negedge clk) begin
    chk("cyc_w8", 32'({busy8, done8, cout8, ovf8, sum8}),
        32'({m_busy[0], m_done[0], m_cout[0], m_ovf[0], m_sum[0]}));
    chk("cyc_w2", 32'({busy2, done2, cout2, ovf2, sum2}),
        32'({m_busy[1], m_done[1], m_cout[1], m_ovf[1], m_sum[1][1:0]}));
    chk("cyc_w1", 32'({busy1, done1, cout1, ovf1, sum1}),
        32'({m_busy[2], m_done[2], m_cout[2], m_ovf[2], m_sum[2][0]}));
  end

  task automatic go(input logic o, input logic c, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    op = o; cin = c; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done8; cyc counts negedges starting at 1
  task automatic wait_done8(output int cyc, output int bc);
    cyc = 1;
    bc  = busy8 ? 1 : 0;
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy8) bc++;
    end
    if (!done8) chk("done8_timeout", 32'(done8), 32'd1);
  endtask

  task automatic run8(input string nm, input logic o, input logic c,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec, input logic eo);
    int cyc;
    int bc;
    go(o, c, av, bv);
    wait_done8(cyc, bc);
    chk({nm, "_res"}, 32'({cout8, ovf8, sum8}), 32'({ec, eo, es}));
    chk({nm, "_lat"}, 32'(cyc), 32'd9);
    chk({nm, "_busy"}, 32'(bc), 32'd8);
  endtask

  task automatic count_done8(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
  endtask

  initial begin
    int cyc;
    int bc;
    int cnt;
    int w;
    logic [5:0] v;
    logic [2:0] t;
    logic [1:0] s;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("reset_w8", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run8("add_0f_01", 1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
    run8("add_ff_01", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run8("add_7f_01", 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run8("add_cin",   1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
    run8("sub_05_07", 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run8("sub_80_01", 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run8("sub_bin",   1'b1, 1'b1, 8'h10, 8'h10, 8'hFF, 1'b0, 1'b0);

    // Start re-pulsed and operands changed mid-operation
    go(1'b0, 1'b0, 8'h0F, 8'h01);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done8(cyc, bc);
    chk("repulse_res", 32'({cout8, ovf8, sum8}), 32'({1'b0, 1'b0, 8'h10}));
    count_done8(12, cnt);
    chk("repulse_extra_done", 32'(cnt), 32'd0);

    // Start held through DONE: back-to-back
    @(negedge clk);
    op = 1'b0; cin = 1'b0; a = 8'h0F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'h7F; b = 8'h01;
    wait_done8(cyc, bc);
    chk("b2b_first", 32'({cout8, ovf8, sum8}), 32'({1'b0, 1'b0, 8'h10}));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_idle", 32'(busy8), 32'd1);
    wait_done8(cyc, bc);
    chk("b2b_second", 32'({cout8, ovf8, sum8}), 32'({1'b0, 1'b1, 8'h80}));
    chk("b2b_lat", 32'(cyc), 32'd9);

    // Asynchronous reset after four bits
    go(1'b0, 1'b0, 8'h0F, 8'h01);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done8(12, cnt);
    chk("rst_no_done", 32'(cnt), 32'd0);
    run8("after_rst", 1'b0, 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

    // WIDTH=2 exhaustive, checked by the per-cycle compare
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      go(v[5], v[4], {6'b0, v[3:2]}, {6'b0, v[1:0]});
      w = 0;
      while (!done2 && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (!done2) chk("done2_timeout", 32'(done2), 32'd1);
    end

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      go(1'b0, t[0], {7'b0, t[2]}, {7'b0, t[1]});
      w = 0;
      while (!done1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (!done1) chk("done1_timeout", 32'(done1), 32'd1);
      s = 2'(t[2]) + 2'(t[1]) + 2'(t[0]);
      chk("fa_truth", 32'({cout1, sum1}), 32'(s));
    end

    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
